// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: load/store unit that moves RV32I byte/half/word accesses over a word-wide memory bus
// with alignment checks, lane steering, load extension and an ack timeout.
module mem_access_ctrl #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        lam_new,
  input  logic        lam_rw,
  input  logic [2:0]  lam_type,
  input  logic [4:0]  lam_sel_out,
  input  logic [31:0] lam_wdata,
  input  logic [31:0] addr,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        wb_en,
  output logic [4:0]  wb_sel,
  output logic [31:0] wb_data,
  output logic        busy,
  output logic        lam_err
);
  typedef enum logic [1:0] {IDLE, REQ, WB, ERR} state_t;
  state_t      state;
  logic        rw;
  logic [2:0]  ty;
  logic [4:0]  sel;
  logic [1:0]  lo;
  logic [15:0] cnt;
  logic        legal;
  logic        misaligned;
  logic [31:0] sdata;
  logic [3:0]  sstrb;
  logic [7:0]  rbyte;
  logic [15:0] rhalf;
  logic [31:0] fmt;
  always_comb begin
    misaligned = (lam_type[1:0] == 2'b01 && addr[0]) || (lam_type[1:0] == 2'b10 && addr[1:0] != 2'b00);
    legal = (lam_rw ? (lam_type <= 3'b010) : !(lam_type inside {3'b011, 3'b110, 3'b111})) && !misaligned;
    sdata = lam_type[1:0] == 2'b00 ? {4{lam_wdata[7:0]}} :
            lam_type[1:0] == 2'b01 ? {2{lam_wdata[15:0]}} : lam_wdata;
    sstrb = lam_type[1:0] == 2'b00 ? 4'b0001 << addr[1:0] :
            lam_type[1:0] == 2'b01 ? (addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    rbyte = mem_rdata[{lo, 3'b000} +: 8];
    rhalf = lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    fmt = ty == 3'b000 ? {{24{rbyte[7]}}, rbyte} :
          ty == 3'b100 ? {24'd0, rbyte} :
          ty == 3'b001 ? {{16{rhalf[15]}}, rhalf} :
          ty == 3'b101 ? {16'd0, rhalf} : mem_rdata;
    busy = rst_n && (state != IDLE || lam_new);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rw        <= 1'b0;
      ty        <= 3'd0;
      sel       <= 5'd0;
      lo        <= 2'd0;
      cnt       <= 16'd0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
      mem_wstrb <= 4'd0;
      wb_en     <= 1'b0;
      wb_sel    <= 5'd0;
      wb_data   <= 32'd0;
      lam_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (lam_new) begin
          rw        <= lam_rw;
          ty        <= lam_type;
          sel       <= lam_sel_out;
          lo        <= addr[1:0];
          cnt       <= 16'd0;
          mem_addr  <= {addr[31:2], 2'b00};
          mem_we    <= lam_rw;
          mem_wdata <= lam_rw ? sdata : 32'd0;
          mem_wstrb <= lam_rw ? sstrb : 4'd0;
          mem_req   <= legal;
          lam_err   <= !legal;
          state     <= legal ? REQ : ERR;
        end
        REQ: if (mem_ack) begin
          mem_req <= 1'b0;
          wb_en   <= !rw && sel != 5'd0;
          wb_sel  <= rw ? wb_sel : sel;
          wb_data <= rw ? wb_data : fmt;
          state   <= rw ? IDLE : WB;
        end else begin
          // the count reaching the limit only aborts when no ack arrived this cycle
          cnt <= cnt + 16'd1;
          if (cnt == 16'(TIMEOUT_CYCLES - 1)) begin
            mem_req <= 1'b0;
            lam_err <= 1'b1;
            state   <= ERR;
          end
        end
        WB: begin
          wb_en <= 1'b0;
          state <= IDLE;
        end
        default: begin
          lam_err <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed vector table for single accesses plus hand sequences for
// timeout, ack-at-limit, ignored lam_new and reset abandonment.
module tb_mem_access_ctrl;
  logic        clk = 0;
  logic        rst_n = 0;
  logic        lam_new = 0, lam_rw = 0;
  logic [2:0]  lam_type = 0;
  logic [4:0]  lam_sel_out = 0;
  logic [31:0] lam_wdata = 0, addr = 0;
  logic        mem_req, mem_we, mem_ack = 0;
  logic [31:0] mem_addr, mem_wdata, mem_rdata = 0;
  logic [3:0]  mem_wstrb;
  logic        wb_en, busy, lam_err;
  logic [4:0]  wb_sel;
  logic [31:0] wb_data;
  int checks = 0, failures = 0;

  mem_access_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .lam_new(lam_new), .lam_rw(lam_rw), .lam_type(lam_type),
    .lam_sel_out(lam_sel_out), .lam_wdata(lam_wdata), .addr(addr),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .wb_en(wb_en), .wb_sel(wb_sel), .wb_data(wb_data), .busy(busy), .lam_err(lam_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rw;
    logic [2:0]  ty;
    logic [4:0]  sel;
    logic [31:0] wd, ad, rd;
    logic        err;
    logic [31:0] ma, mwd;
    logic [3:0]  ws;
    logic        wbe;
    logic [31:0] wbd;
  } vec_t;
  vec_t v [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic issue(input logic rw, input logic [2:0] ty, input logic [4:0] sel,
                       input logic [31:0] wd, input logic [31:0] ad);
    @(negedge clk);
    lam_new = 1; lam_rw = rw; lam_type = ty; lam_sel_out = sel; lam_wdata = wd; addr = ad;
    #1 chk("busy_on_new", 32'(busy), 32'd1);
    @(posedge clk); #1;
    lam_new = 0;
  endtask

  task automatic run_vec(input vec_t t);
    issue(t.rw, t.ty, t.sel, t.wd, t.ad);
    if (t.err) begin
      chk("err_pulse", 32'(lam_err), 32'd1);
      chk("err_no_req", 32'(mem_req), 32'd0);
      @(posedge clk); #1;
      chk("err_clear", 32'(lam_err), 32'd0);
      chk("err_req_never", 32'(mem_req), 32'd0);
      chk("err_idle", 32'(busy), 32'd0);
    end else begin
      chk("req", 32'(mem_req), 32'd1);
      chk("maddr", mem_addr, t.ma);
      chk("we", 32'(mem_we), 32'(t.rw));
      chk("wstrb", 32'(mem_wstrb), 32'(t.ws));
      if (t.rw) chk("mwdata", mem_wdata, t.mwd);
      mem_ack = 1; mem_rdata = t.rd;
      @(posedge clk); #1;
      mem_ack = 0;
      chk("req_drop", 32'(mem_req), 32'd0);
      chk("wb_en", 32'(wb_en), 32'(t.wbe));
      if (t.wbe) begin
        chk("wb_sel", 32'(wb_sel), 32'(t.sel));
        chk("wb_data", wb_data, t.wbd);
      end
      if (!t.rw) begin
        chk("wb_busy", 32'(busy), 32'd1);
        @(posedge clk); #1;
        chk("wb_one_cycle", 32'(wb_en), 32'd0);
      end
      chk("done_idle", 32'(busy), 32'd0);
    end
  endtask

  initial begin
    v[0]  = '{0, 3'b010, 5, 0, 32'h100, 32'hDEADBEEF, 0, 32'h100, 0, 4'b0000, 1, 32'hDEADBEEF};
    v[1]  = '{0, 3'b000, 1, 0, 32'h103, 32'h80FF0000, 0, 32'h100, 0, 4'b0000, 1, 32'hFFFFFF80};
    v[2]  = '{0, 3'b100, 2, 0, 32'h103, 32'h80FF0000, 0, 32'h100, 0, 4'b0000, 1, 32'h00000080};
    v[3]  = '{0, 3'b101, 3, 0, 32'h102, 32'h80FF0000, 0, 32'h100, 0, 4'b0000, 1, 32'h000080FF};
    v[4]  = '{0, 3'b001, 4, 0, 32'h102, 32'h80FF0000, 0, 32'h100, 0, 4'b0000, 1, 32'hFFFF80FF};
    v[5]  = '{1, 3'b000, 0, 32'hAB, 32'h201, 0, 0, 32'h200, 32'hABABABAB, 4'b0010, 0, 0};
    v[6]  = '{1, 3'b001, 0, 32'h1234, 32'h202, 0, 0, 32'h200, 32'h12341234, 4'b1100, 0, 0};
    v[7]  = '{1, 3'b010, 0, 32'hCAFEF00D, 32'h204, 0, 0, 32'h204, 32'hCAFEF00D, 4'b1111, 0, 0};
    v[8]  = '{0, 3'b010, 6, 0, 32'h102, 0, 1, 0, 0, 0, 0, 0};
    v[9]  = '{1, 3'b001, 0, 32'h55, 32'h101, 0, 1, 0, 0, 0, 0, 0};
    v[10] = '{0, 3'b011, 7, 0, 32'h0, 0, 1, 0, 0, 0, 0, 0};
    v[11] = '{1, 3'b100, 0, 32'h1, 32'h0, 0, 1, 0, 0, 0, 0, 0};
    v[12] = '{0, 3'b010, 0, 0, 32'h10, 32'h12345678, 0, 32'h10, 0, 4'b0000, 0, 0};
    v[13] = '{0, 3'b001, 9, 0, 32'h100, 32'h12348765, 0, 32'h100, 0, 4'b0000, 1, 32'hFFFF8765};
    v[14] = '{1, 3'b000, 0, 32'h5A, 32'h203, 0, 0, 32'h200, 32'h5A5A5A5A, 4'b1000, 0, 0};
    lam_new = 1;
    #12;
    chk("rst_req", 32'(mem_req), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_wb_en", 32'(wb_en), 0);
    chk("rst_err", 32'(lam_err), 0);
    chk("rst_maddr", mem_addr, 0);
    chk("rst_wstrb", 32'(mem_wstrb), 0);
    chk("rst_wb_data", wb_data, 0);
    lam_new = 0;
    @(negedge clk) rst_n = 1;
    for (int i = 0; i < 15; i++) run_vec(v[i]);

    // no ack: four REQ cycles then an error pulse; lam_new during REQ is ignored
    issue(0, 3'b010, 8, 0, 32'h300);
    lam_new = 1; lam_rw = 1; addr = 32'h500;
    for (int i = 0; i < 4; i++) begin
      chk("to_req_high", 32'(mem_req), 1);
      chk("to_addr_held", mem_addr, 32'h300);
      chk("to_we_held", 32'(mem_we), 0);
      if (i == 3) lam_new = 0;
      @(posedge clk); #1;
    end
    chk("to_req_drop", 32'(mem_req), 0);
    chk("to_err", 32'(lam_err), 1);
    chk("to_no_wb", 32'(wb_en), 0);
    @(posedge clk); #1;
    chk("to_err_clear", 32'(lam_err), 0);
    chk("to_idle", 32'(busy), 0);

    // ack exactly on the fourth REQ cycle wins over the timeout
    issue(0, 3'b010, 8, 0, 32'h300);
    for (int i = 0; i < 3; i++) begin @(posedge clk); #1; end
    chk("ack4_req", 32'(mem_req), 1);
    mem_ack = 1; mem_rdata = 32'h0BADF00D;
    @(posedge clk); #1;
    mem_ack = 0;
    chk("ack4_no_err", 32'(lam_err), 0);
    chk("ack4_wb_en", 32'(wb_en), 1);
    chk("ack4_wb_data", wb_data, 32'h0BADF00D);
    @(posedge clk); #1;
    chk("ack4_idle", 32'(busy), 0);

    // reset in the second REQ cycle abandons the access; late ack ignored
    issue(0, 3'b010, 7, 0, 32'h400);
    @(posedge clk); #1;
    chk("rr_req", 32'(mem_req), 1);
    #2 rst_n = 0;
    #1;
    chk("rr_req_async", 32'(mem_req), 0);
    chk("rr_busy", 32'(busy), 0);
    @(negedge clk);
    rst_n = 1; mem_ack = 1; mem_rdata = 32'hFFFFFFFF;
    @(posedge clk); #1;
    mem_ack = 0;
    chk("rr_no_wb", 32'(wb_en), 0);
    chk("rr_no_req", 32'(mem_req), 0);
    chk("rr_idle", 32'(busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  always @(negedge clk)
    if (rst_n && ((wb_en && lam_err) || (wb_en && mem_req) || (lam_err && mem_req))) begin
      failures++;
      $display("FAIL exclusive_outputs: wb_en=%b lam_err=%b mem_req=%b", wb_en, lam_err, mem_req);
    end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning the maximum number of cycles to wait for mem_ack before abort (1..65535).
REQ-002 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port lam_new  in  1  decoder flag for a new load/store; sampled only in IDLE.
REQ-005 SHALL have port lam_rw  in  1  0 = load, 1 = store.
REQ-006 SHALL have port lam_type  in  3  RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW).
REQ-007 SHALL have port lam_sel_out  in  5  load destination register.
REQ-008 SHALL have port lam_wdata  in  32  store source register value, already read through lam_rs.
REQ-009 SHALL have port addr  in  32  effective address from ALU (rs1 + imm).
REQ-010 SHALL have ports mem_req out 1, mem_we out 1, mem_addr out 32, mem_wdata out 32, mem_wstrb out 4, mem_ack in 1, mem_rdata in 32, forming the word-wide memory bus.
REQ-011 SHALL have ports wb_en out 1, wb_sel out 5, wb_data out 32 for register-file writeback.
REQ-012 SHALL have ports busy out 1 (pipeline stall) and lam_err out 1 (fault pulse).

Function
REQ-013 SHALL implement the FSM states IDLE, REQ, WB, and ERR.
REQ-014 In IDLE, when lam_new=1, SHALL latch lam_rw, lam_type, lam_sel_out, lam_wdata, and addr, then go to REQ if the access is legal, else to ERR.
REQ-015 An access SHALL be illegal when: for loads, lam_type is 011, 110, or 111; for stores, lam_type is above 010; for LH/LHU/SH, addr[0]=1; for LW/SW, addr[1:0] is not 00.
REQ-016 busy SHALL be combinationally high when lam_new=1 in IDLE and SHALL stay high in every non-IDLE state.
REQ-017 In REQ, mem_req SHALL be 1 and mem_addr SHALL be {addr[31:2],2'b00}; mem_we, mem_wdata, and mem_wstrb SHALL be stable until the cycle in which mem_ack=1.
REQ-018 Store lanes: SB SHALL replicate the byte to all 4 lanes with wstrb = 0001<<addr[1:0]; SH SHALL replicate the halfword with wstrb 0011 (addr[1]=0) or 1100; SW SHALL use wstrb 1111.
REQ-019 Loads SHALL drive mem_we=0 and mem_wstrb=0000.
REQ-020 When mem_ack=1 in REQ, mem_req SHALL drop the next cycle; a store SHALL then go to IDLE, and a load SHALL capture the formatted mem_rdata and go to WB.
REQ-021 Load formatting: LB/LBU SHALL select the byte at addr[1:0] with sign/zero extension; LH/LHU SHALL select the halfword at addr[1] with sign/zero extension; LW SHALL pass all 32 bits.
REQ-022 WB SHALL last exactly one cycle: wb_en=1 unless the latched sel_out is 0, wb_sel is the latched sel_out, wb_data is the captured value; the FSM then returns to IDLE.
REQ-023 Latency with mem_ack returned in the first REQ cycle: lam_new in cycle N, mem_req in N+1, wb_en in N+2, busy low in N+3.
REQ-024 A 16-bit wait counter SHALL clear on REQ entry and increment each REQ cycle without ack.
REQ-025 If the count reaches TIMEOUT_CYCLES with no ack, the block SHALL drop mem_req and go to ERR.
REQ-026 An ack arriving in the same cycle the count reaches TIMEOUT_CYCLES SHALL win, giving normal completion.
REQ-027 ERR SHALL last one cycle with lam_err=1, no memory access, and no writeback, then return to IDLE.
REQ-028 lam_new outside IDLE SHALL be ignored.
REQ-029 mem_ack outside REQ SHALL be ignored.
REQ-030 A new lam_new in the IDLE cycle right after completion SHALL be accepted (back-to-back).
REQ-031 wb_en, lam_err, and mem_req SHALL never be high in the same cycle.

Reset
REQ-032 While rst_n=0, state SHALL be IDLE and mem_req, mem_we, wb_en, lam_err, and busy SHALL be 0; mem_wstrb=0, mem_addr=0, mem_wdata=0, wb_sel=0, wb_data=0; the counter SHALL be 0.
REQ-033 An rst_n assertion in REQ or WB SHALL drop mem_req/wb_en immediately (asynchronously) and abandon the access; a late mem_ack after release SHALL be ignored.

Verification
REQ-034 LW to addr 0x100, sel_out 5, ack in the first REQ cycle with rdata 0xDEADBEEF -> mem_addr 0x100, wb_en in N+2 with wb_sel 5, wb_data 0xDEADBEEF.
REQ-035 LB at 0x103 with rdata 0x80FF0000 -> wb_data 0xFFFFFF80; LBU at the same address -> 0x00000080; LHU at 0x102 -> 0x000080FF.
REQ-036 SB at 0x201 with wdata 0x000000AB -> mem_wdata 0xABABABAB, wstrb 0010, we=1; SH at 0x202 with wdata 0x1234 -> wdata 0x12341234, wstrb 1100; no wb_en.
REQ-037 LW at 0x102 and SH at 0x101 -> lam_err pulses one cycle each, mem_req never asserted.
REQ-038 TIMEOUT_CYCLES=4, mem_ack held 0 -> mem_req high for 4 cycles, then lam_err pulses; an ack exactly on the 4th cycle instead completes normally.
REQ-039 rst_n pulled low in the second REQ cycle, then mem_ack=1 after release -> mem_req 0 immediately, no wb_en, state IDLE; a load to sel_out 0 -> wb_en stays 0.
